// File: rtl/combat_pkg.sv
// combat_pkg: encodings shared by the character FSM, hit detection and the
// combat resolver.
//   ATTACK            character FSM state in which a hitbox is live
//   WIN_*             round result codes driven on combat_resolver.winner
//   resolver_state_t  round state of the resolver (FIGHT / OVER)
package combat_pkg;

  localparam logic [2:0] ATTACK = 3'b010;

  localparam logic [1:0] WIN_NONE = 2'b00;
  localparam logic [1:0] WIN_P1   = 2'b01;
  localparam logic [1:0] WIN_P2   = 2'b10;
  localparam logic [1:0] WIN_DRAW = 2'b11;

  typedef enum logic {
    FIGHT = 1'b0,
    OVER  = 1'b1
  } resolver_state_t;

endpackage

// File: rtl/player_damage.sv
// player_damage: damage bookkeeping for one defending player.
//   clk, rst      clock, asynchronous active-high reset
//   hit_accept    an accepted hit lands on this player this edge
//   frame_tick    one-clk strobe per video frame (stun time base)
//   restore       new-round request: refill health, clear stun
//   health        current health, saturating at 0
//   hitstun       player is stunned (stun counter nonzero)
//   hit_pulse     one-cycle pulse on the edge after an accepted hit
module player_damage
  import combat_pkg::*;
#(
  parameter int unsigned MAX_HEALTH     = 3,
  parameter int unsigned HITSTUN_FRAMES = 12,
  parameter int unsigned HW             = $clog2(MAX_HEALTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          hit_accept,
  input  logic          frame_tick,
  input  logic          restore,
  output logic [HW-1:0] health,
  output logic          hitstun,
  output logic          hit_pulse
);

  logic [7:0] stun_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      health    <= HW'(MAX_HEALTH);
      stun_cnt  <= '0;
      hit_pulse <= 1'b0;
    end else if (restore) begin
      health    <= HW'(MAX_HEALTH);
      stun_cnt  <= '0;
      hit_pulse <= 1'b0;
    end else begin
      hit_pulse <= hit_accept;
      if (hit_accept) begin
        if (health != '0) health <= health - HW'(1);
        // A fresh hit reloads the stun even if a frame tick arrives together.
        stun_cnt <= 8'(HITSTUN_FRAMES);
      end else if (frame_tick && stun_cnt != '0) begin
        stun_cnt <= stun_cnt - 8'd1;
      end
    end
  end

  assign hitstun = (stun_cnt != '0);

endmodule

// File: rtl/combat_resolver.sv
// combat_resolver: turns level-valued hitbox overlap flags into one hit event
// per attack, applies damage/hitstun to each player and decides the round.
//   clk, rst                   clock, asynchronous active-high reset
//   frame_tick                 one-clk strobe per video frame
//   round_restart              one-cycle new-round request (beats any hit)
//   char1_state, char2_state   character FSM states (ATTACK = 3'b010)
//   hit1_lands, hit2_lands     P1 hits P2 / P2 hits P1 overlap levels
//   p1_health, p2_health       current health per player
//   p1_hitstun, p2_hitstun     player currently stunned
//   p1_hit_pulse, p2_hit_pulse one-cycle pulse when that player takes damage
//   game_over                  round finished
//   winner                     00 none, 01 P1, 10 P2, 11 draw
module combat_resolver
  import combat_pkg::*;
#(
  parameter int unsigned MAX_HEALTH     = 3,
  parameter int unsigned HITSTUN_FRAMES = 12
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               frame_tick,
  input  logic                               round_restart,
  input  logic [2:0]                         char1_state,
  input  logic [2:0]                         char2_state,
  input  logic                               hit1_lands,
  input  logic                               hit2_lands,
  output logic [$clog2(MAX_HEALTH + 1)-1:0]  p1_health,
  output logic [$clog2(MAX_HEALTH + 1)-1:0]  p2_health,
  output logic                               p1_hitstun,
  output logic                               p2_hitstun,
  output logic                               p1_hit_pulse,
  output logic                               p2_hit_pulse,
  output logic                               game_over,
  output logic [1:0]                         winner
);

  localparam int unsigned HW = $clog2(MAX_HEALTH + 1);

  resolver_state_t state;
  logic            atk1_consumed;
  logic            atk2_consumed;
  logic            accept1;
  logic            accept2;
  logic            kill_p1;
  logic            kill_p2;

  // accept1: P1 damages P2; accept2: P2 damages P1. Restart drops any hit.
  always_comb begin
    accept1 = (state == FIGHT) && !round_restart && hit1_lands &&
              (char1_state == ATTACK) && !atk1_consumed && !p2_hitstun;
    accept2 = (state == FIGHT) && !round_restart && hit2_lands &&
              (char2_state == ATTACK) && !atk2_consumed && !p1_hitstun;
    // The hit is lethal when the defender sits at 1 (or already 0).
    kill_p2 = accept1 && (p2_health <= HW'(1));
    kill_p1 = accept2 && (p1_health <= HW'(1));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= FIGHT;
      winner        <= WIN_NONE;
      atk1_consumed <= 1'b0;
      atk2_consumed <= 1'b0;
    end else if (round_restart) begin
      state         <= FIGHT;
      winner        <= WIN_NONE;
      atk1_consumed <= 1'b0;
      atk2_consumed <= 1'b0;
    end else begin
      if (accept1)                   atk1_consumed <= 1'b1;
      else if (char1_state != ATTACK) atk1_consumed <= 1'b0;
      if (accept2)                   atk2_consumed <= 1'b1;
      else if (char2_state != ATTACK) atk2_consumed <= 1'b0;

      if (state == FIGHT && (kill_p1 || kill_p2)) begin
        state <= OVER;
        // {P1 died, P2 died} maps directly onto WIN_P2 / WIN_P1 / WIN_DRAW.
        winner <= {kill_p1, kill_p2};
      end
    end
  end

  assign game_over = (state == OVER);

  player_damage #(
    .MAX_HEALTH     (MAX_HEALTH),
    .HITSTUN_FRAMES (HITSTUN_FRAMES),
    .HW             (HW)
  ) u_p1_damage (
    .clk        (clk),
    .rst        (rst),
    .hit_accept (accept2),
    .frame_tick (frame_tick),
    .restore    (round_restart),
    .health     (p1_health),
    .hitstun    (p1_hitstun),
    .hit_pulse  (p1_hit_pulse)
  );

  player_damage #(
    .MAX_HEALTH     (MAX_HEALTH),
    .HITSTUN_FRAMES (HITSTUN_FRAMES),
    .HW             (HW)
  ) u_p2_damage (
    .clk        (clk),
    .rst        (rst),
    .hit_accept (accept1),
    .frame_tick (frame_tick),
    .restore    (round_restart),
    .health     (p2_health),
    .hitstun    (p2_hitstun),
    .hit_pulse  (p2_hit_pulse)
  );

endmodule

// File: tb/tb_combat_resolver.sv
// Testbench for combat_resolver: table vectors, directed round sequences and
// randomized play checked against a behavioural round model.
module tb_combat_resolver;
  import combat_pkg::*;

  localparam int MAXH = 3;
  localparam int HS   = 12;
  localparam logic [2:0] IDLE = 3'b000;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       frame_tick = 1'b0;
  logic       round_restart = 1'b0;
  logic [2:0] char1_state = IDLE;
  logic [2:0] char2_state = IDLE;
  logic       hit1_lands = 1'b0;
  logic       hit2_lands = 1'b0;
  logic [1:0] p1_health, p2_health;
  logic       p1_hitstun, p2_hitstun, p1_hit_pulse, p2_hit_pulse;
  logic       game_over;
  logic [1:0] winner;

  always #5 clk = ~clk;

  combat_resolver #(
    .MAX_HEALTH     (MAXH),
    .HITSTUN_FRAMES (HS)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .frame_tick    (frame_tick),
    .round_restart (round_restart),
    .char1_state   (char1_state),
    .char2_state   (char2_state),
    .hit1_lands    (hit1_lands),
    .hit2_lands    (hit2_lands),
    .p1_health     (p1_health),
    .p2_health     (p2_health),
    .p1_hitstun    (p1_hitstun),
    .p2_hitstun    (p2_hitstun),
    .p1_hit_pulse  (p1_hit_pulse),
    .p2_hit_pulse  (p2_hit_pulse),
    .game_over     (game_over),
    .winner        (winner)
  );

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // Round model: health, remaining stun frames, attack-used flags, round over.
  int mh1, mh2, ms1, ms2, mwin;
  bit mc1, mc2, mover, mp1, mp2;

  task automatic model_reset();
    mh1 = MAXH; mh2 = MAXH; ms1 = 0; ms2 = 0; mwin = 0;
    mc1 = 0; mc2 = 0; mover = 0; mp1 = 0; mp2 = 0;
  endtask

  task automatic model_step(input bit r, input logic [2:0] s1, input logic [2:0] s2,
                            input bit l1, input bit l2, input bit t);
    bit a1, a2, dead1, dead2;
    a1 = l1 && s1 == ATTACK && !mc1 && ms2 == 0 && !mover && !r;
    a2 = l2 && s2 == ATTACK && !mc2 && ms1 == 0 && !mover && !r;
    if (r) begin
      model_reset();
    end else begin
      mp1 = a2;
      mp2 = a1;
      if (a1) begin mh2 = (mh2 > 0) ? mh2 - 1 : 0; ms2 = HS; end
      else if (t && ms2 > 0) ms2--;
      if (a2) begin mh1 = (mh1 > 0) ? mh1 - 1 : 0; ms1 = HS; end
      else if (t && ms1 > 0) ms1--;
      mc1 = a1 ? 1'b1 : (s1 != ATTACK ? 1'b0 : mc1);
      mc2 = a2 ? 1'b1 : (s2 != ATTACK ? 1'b0 : mc2);
      dead2 = a1 && mh2 == 0;
      dead1 = a2 && mh1 == 0;
      if (!mover && (dead1 || dead2)) begin
        mover = 1;
        mwin = (dead1 && dead2) ? 3 : (dead2 ? 1 : 2);
      end
    end
  endtask

  task automatic compare_all(input string tag);
    check({tag, ".p1_health"},  int'(p1_health),    mh1);
    check({tag, ".p2_health"},  int'(p2_health),    mh2);
    check({tag, ".p1_hitstun"}, int'(p1_hitstun),   int'(ms1 != 0));
    check({tag, ".p2_hitstun"}, int'(p2_hitstun),   int'(ms2 != 0));
    check({tag, ".p1_pulse"},   int'(p1_hit_pulse), int'(mp1));
    check({tag, ".p2_pulse"},   int'(p2_hit_pulse), int'(mp2));
    check({tag, ".game_over"},  int'(game_over),    int'(mover));
    check({tag, ".winner"},     int'(winner),       mwin);
  endtask

  // Inputs change 1 time unit after the active edge; outputs sampled there too.
  task automatic drive(input string tag, input bit r, input logic [2:0] s1,
                       input logic [2:0] s2, input bit l1, input bit l2, input bit t);
    round_restart = r; char1_state = s1; char2_state = s2;
    hit1_lands = l1; hit2_lands = l2; frame_tick = t;
    @(posedge clk);
    #1;
    model_step(r, s1, s2, l1, l2, t);
    compare_all(tag);
  endtask

  task automatic idle_ticks(input string tag, input int n);
    for (int i = 0; i < n; i++) drive(tag, 0, IDLE, IDLE, 0, 0, 1);
  endtask

  typedef struct {
    bit r; logic [2:0] s1; logic [2:0] s2; bit l1; bit l2; bit t;
    int h1; int h2; bit st1; bit st2; bit pu1; bit pu2; bit go; int win;
  } vec_t;

  vec_t tbl[7];
  int   pulses;
  int   ticks;

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    //         r  s1     s2     l1 l2 t  h1 h2 st1 st2 pu1 pu2 go win
    tbl[0] = '{0, IDLE,   IDLE,   0, 0, 0, 3, 3, 0, 0, 0, 0, 0, 0};
    tbl[1] = '{0, ATTACK, IDLE,   1, 0, 0, 3, 2, 0, 1, 0, 1, 0, 0};
    tbl[2] = '{0, ATTACK, IDLE,   1, 0, 0, 3, 2, 0, 1, 0, 0, 0, 0};
    tbl[3] = '{0, ATTACK, ATTACK, 1, 1, 0, 2, 2, 1, 1, 1, 0, 0, 0};
    tbl[4] = '{1, ATTACK, ATTACK, 1, 1, 0, 3, 3, 0, 0, 0, 0, 0, 0};
    tbl[5] = '{0, ATTACK, ATTACK, 1, 1, 1, 2, 2, 1, 1, 1, 1, 0, 0};
    tbl[6] = '{1, IDLE,   IDLE,   0, 0, 0, 3, 3, 0, 0, 0, 0, 0, 0};

    model_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    compare_all("reset");
    rst = 1'b0;

    // Table vectors
    foreach (tbl[i]) begin
      drive($sformatf("tbl%0d", i), tbl[i].r, tbl[i].s1, tbl[i].s2,
            tbl[i].l1, tbl[i].l2, tbl[i].t);
      check($sformatf("tbl%0d.h1", i),  int'(p1_health),    tbl[i].h1);
      check($sformatf("tbl%0d.h2", i),  int'(p2_health),    tbl[i].h2);
      check($sformatf("tbl%0d.st1", i), int'(p1_hitstun),   int'(tbl[i].st1));
      check($sformatf("tbl%0d.st2", i), int'(p2_hitstun),   int'(tbl[i].st2));
      check($sformatf("tbl%0d.pu1", i), int'(p1_hit_pulse), int'(tbl[i].pu1));
      check($sformatf("tbl%0d.pu2", i), int'(p2_hit_pulse), int'(tbl[i].pu2));
      check($sformatf("tbl%0d.go", i),  int'(game_over),    int'(tbl[i].go));
      check($sformatf("tbl%0d.win", i), int'(winner),       tbl[i].win);
    end

    // Held overlap for 20 cycles: one hit only, then a 12-tick stun.
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      drive("hold", 0, ATTACK, IDLE, 1, 0, 0);
      pulses += int'(p2_hit_pulse);
    end
    check("hold.pulses", pulses, 1);
    check("hold.h2", int'(p2_health), 2);
    ticks = 0;
    for (int i = 0; i < 40 && p2_hitstun; i++) begin
      drive("stun", 0, IDLE, IDLE, 0, 0, 1);
      ticks++;
    end
    check("stun.ticks", ticks, HS);

    // Re-attack after stun expired
    drive("reatk", 0, ATTACK, IDLE, 1, 0, 0);
    check("reatk.h2", int'(p2_health), 1);
    check("reatk.pulse", int'(p2_hit_pulse), 1);

    // Re-attack while stunned: lands once the stun ends, and it is lethal.
    drive("leave", 0, IDLE, IDLE, 0, 0, 0);
    pulses = 0;
    for (int i = 0; i < 30; i++) begin
      drive("stunatk", 0, ATTACK, IDLE, 1, 0, 1);
      pulses += int'(p2_hit_pulse);
      if (i == HS - 1) check("stunatk.early_h2", int'(p2_health), 1);
    end
    check("stunatk.pulses", pulses, 1);
    check("kill.h2", int'(p2_health), 0);
    check("kill.go", int'(game_over), 1);
    check("kill.win", int'(winner), int'(WIN_P1));

    // Restart coinciding with a P2 hit: restart wins
    drive("restart", 1, IDLE, ATTACK, 0, 1, 0);
    check("restart.h1", int'(p1_health), MAXH);
    check("restart.h2", int'(p2_health), MAXH);
    check("restart.win", int'(winner), int'(WIN_NONE));
    check("restart.pu1", int'(p1_hit_pulse), 0);
    check("restart.go", int'(game_over), 0);

    // Three trades -> draw
    for (int k = 0; k < 3; k++) begin
      drive("trade", 0, ATTACK, ATTACK, 1, 1, 0);
      if (k < 2) idle_ticks("trade_idle", HS);
    end
    check("draw.h1", int'(p1_health), 0);
    check("draw.h2", int'(p2_health), 0);
    check("draw.go", int'(game_over), 1);
    check("draw.win", int'(winner), int'(WIN_DRAW));
    drive("restart2", 1, IDLE, IDLE, 0, 0, 0);

    // Async reset mid-stun with P2 at health 1
    drive("e1", 0, ATTACK, IDLE, 1, 0, 0);
    idle_ticks("e_idle", HS);
    drive("e2", 0, ATTACK, IDLE, 1, 0, 0);
    drive("e3", 0, ATTACK, IDLE, 1, 0, 1);
    check("pre_rst.h2", int'(p2_health), 1);
    #3;
    rst = 1'b1;
    #1;
    model_reset();
    compare_all("async_rst");
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive("post_rst", 0, IDLE, IDLE, 0, 0, 0);
      check("post_rst.pu2", int'(p2_hit_pulse), 0);
    end

    // Randomized play against the model
    for (int i = 0; i < 3000; i++) begin
      logic [2:0] s1, s2;
      s1 = ($urandom_range(0, 3) != 0) ? ATTACK : 3'($urandom_range(0, 7));
      s2 = ($urandom_range(0, 3) != 0) ? ATTACK : 3'($urandom_range(0, 7));
      drive("rand", ($urandom_range(0, 59) == 0), s1, s2,
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
